instr_fetch_ctrl: RTL and testbench
===================================

// Module: instr_fetch_ctrl
// PURPOSE
//  Fetch stage between the PC register and instruction memory. Takes the current PC and
//  runs a req/gnt + rvalid handshake to a variable-latency instruction memory. Holds the
//  returned word for the decode/execute path until it is acknowledged.
//  Raises stall so the PC register holds during a fetch, and discards in-flight responses
//  on a redirect (flush).
// PARAMETERS
//  XLEN      32            address/data width
//  TIMEOUT   16            max cycles waiting for imem_rvalid before declaring fetch error (>=2)
//  NOP_INSTR 32'h00000013  word presented on reset, error or misalign (addi x0,x0,0)
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     reset, asynchronous assert, active-low
//  pc           in   XLEN  fetch address from PC register
//  fetch_req    in   1     core requests fetch of pc this cycle
//  flush        in   1     redirect: abandon current fetch / held instruction
//  instr_ack    in   1     core consumed instr this cycle
//  imem_req     out  1     memory request (registered)
//  imem_addr    out  XLEN  memory address (registered, stable while imem_req)
//  imem_gnt     in   1     memory accepted request this cycle
//  imem_rvalid  in   1     read data valid
//  imem_rdata   in   XLEN  read data
//  instr        out  XLEN  fetched instruction (registered)
//  instr_pc     out  XLEN  address instr was fetched from
//  instr_valid  out  1     instr/instr_pc valid, held until instr_ack
//  fetch_err    out  1     qualifies instr_valid: timeout occurred, instr = NOP_INSTR
//  stall        out  1     combinational: state in {REQ,WAIT,DRAIN}; PC must hold
// BEHAVIOUR
//  Reset (async): state IDLE; imem_req 0, imem_addr 0, instr NOP_INSTR, instr_pc 0,
//   instr_valid 0, fetch_err 0, timeout count 0; stall 0.
//  States IDLE, REQ, WAIT, DONE, DRAIN. flush has priority over all other inputs.
//  fetch_req is sampled only in IDLE, or in DONE together with instr_ack; it is ignored otherwise.
//  IDLE: fetch_req & !flush -> REQ; imem_addr<=pc, imem_req<=1.
//  REQ: imem_req held with constant addr until gnt. gnt -> WAIT, imem_req<=0.
//   flush & !gnt -> IDLE (req dropped). flush & gnt -> DRAIN.
//  WAIT: rvalid -> DONE; instr<=rdata, instr_pc<=imem_addr, instr_valid<=1, fetch_err<=0.
//   Count reaches TIMEOUT-1 without rvalid -> DONE, instr<=NOP_INSTR, fetch_err<=1.
//   flush & rvalid -> IDLE (data discarded). flush & !rvalid -> DRAIN.
//  DONE: instr_valid=1 until instr_ack. ack & fetch_req -> REQ (back-to-back, addr<=pc).
//   ack alone -> IDLE. Both clear instr_valid. flush -> IDLE, instr_valid<=0.
//  DRAIN: wait for one rvalid, discard it -> IDLE. Timeout -> IDLE, no error reported.
//   flush is ignored in DRAIN.
//  Timeout counter clears on entry to WAIT/DRAIN and increments each cycle in those states.
//  imem_rvalid outside WAIT/DRAIN is ignored. A gnt late by one cycle is the memory's fault.
//  Minimum latency: fetch_req cycle 0, imem_req 1, gnt 1, rvalid 2, instr_valid 3.
//  Only one request is outstanding at any time.
//  Reset mid-operation returns to IDLE immediately. A response arriving after reset is ignored.
// CONFIGURATION
//  INSTR_ALIGN_CHECK_EN defined: in IDLE/DONE, a fetch with pc[1:0]!=0 issues no memory
//   request. Next state is DONE with instr=NOP_INSTR, instr_pc=pc, instr_valid=1 and an
//   extra output instr_misalign=1. instr_misalign clears with instr_valid.
//  Undefined: no instr_misalign port; pc[1:0] is passed to imem_addr unchanged.
// STRUCTURE
//  Package fetch_pkg: state enum fetch_state_t, NOP_INSTR constant, XLEN default.
//  Sub-module fetch_timeout_ctr: clear/enable counter, width $clog2(TIMEOUT), expired flag.
//  FSM, data regs and stall decode live in top.
// TESTING
//  1 fetch_req pc=0x100, gnt same cycle as req, rvalid next cycle data=0x00500093
//    -> instr_valid at cycle 3, instr=0x00500093, instr_pc=0x100; stall high in cycles 1-2.
//  2 gnt delayed 3 cycles -> imem_req/imem_addr=0x104 stable for 4 cycles.
//    Then rvalid -> correct instr.
//  3 flush in WAIT, rvalid 2 cycles later data=0xDEADBEEF
//    -> DRAIN, word discarded, instr_valid stays 0, then IDLE; next fetch 0x200 OK.
//  4 no rvalid for TIMEOUT cycles -> instr_valid=1, fetch_err=1, instr=0x00000013.
//  5 instr_ack with fetch_req pc=0x108 in DONE -> REQ next cycle without passing IDLE.
//    Only one imem_req outstanding.
//  6 (INSTR_ALIGN_CHECK_EN) fetch pc=0x102
//    -> no imem_req, instr_misalign=1, instr=NOP, instr_pc=0x102.

Source files
------------

// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Instruction memory req/gnt + rvalid bus; master is the fetch controller.
interface instr_fetch_ctrl_if #(
  parameter int unsigned XLEN = fetch_pkg::XLEN
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/instr_fetch_ctrl_timeout_ctr.sv
// Response timeout counter: clear/enable, saturates at TIMEOUT-1, flags expiry.
module fetch_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  assign expired_c = (count == CW'(TIMEOUT - 1));

  // Count cycles spent waiting for a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired_c) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch stage: issues one instruction memory read at a time, holds the word
// until acknowledged, drains abandoned responses after a flush.
// Optional build macro: INSTR_ALIGN_CHECK_EN (reject pc[1:0]!=0 without a bus access).
module instr_fetch_ctrl #(
  parameter int unsigned     XLEN      = fetch_pkg::XLEN,
  parameter int unsigned     TIMEOUT   = 16,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(fetch_pkg::NOP_INSTR)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [XLEN-1:0]     pc,
  input  logic                fetch_req,
  input  logic                flush,
  input  logic                instr_ack,
  instr_fetch_ctrl_if.master  imem,
  output logic [XLEN-1:0]     instr,
  output logic [XLEN-1:0]     instr_pc,
  output logic                instr_valid,
  output logic                fetch_err,
`ifdef INSTR_ALIGN_CHECK_EN
  output logic                instr_misalign,
`endif
  output logic                stall
);

  import fetch_pkg::*;

  fetch_state_t state;
  logic         take_fetch;
  logic         pc_misaligned;
  logic         tmo_clr;
  logic         tmo_en;
  logic         tmo_expired;

`ifdef INSTR_ALIGN_CHECK_EN
  assign pc_misaligned = (pc[1:0] != 2'b00);
`else
  assign pc_misaligned = 1'b0;
`endif

  // fetch_req is only honoured from IDLE, or from DONE together with the ack.
  assign take_fetch = fetch_req && !flush &&
                      ((state == ST_IDLE) || ((state == ST_DONE) && instr_ack));

  assign stall = (state == ST_REQ) || (state == ST_WAIT) || (state == ST_DRAIN);

  // Counter runs in WAIT/DRAIN; restarts when WAIT hands over to DRAIN.
  assign tmo_en  = (state == ST_WAIT) || (state == ST_DRAIN);
  assign tmo_clr = !tmo_en || ((state == ST_WAIT) && flush && !imem.imem_rvalid);

  fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (tmo_clr),
    .en        (tmo_en),
    .expired_c (tmo_expired)
  );

  // Fetch FSM with registered bus and instruction outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= '0;
      instr          <= NOP_INSTR;
      instr_pc       <= '0;
      instr_valid    <= 1'b0;
      fetch_err      <= 1'b0;
`ifdef INSTR_ALIGN_CHECK_EN
      instr_misalign <= 1'b0;
`endif
    end else if (take_fetch) begin
      fetch_err   <= 1'b0;
      instr_valid <= pc_misaligned;
`ifdef INSTR_ALIGN_CHECK_EN
      instr_misalign <= pc_misaligned;
`endif
      if (pc_misaligned) begin
        state    <= ST_DONE;
        instr    <= NOP_INSTR;
        instr_pc <= pc;
      end else begin
        state          <= ST_REQ;
        imem.imem_req  <= 1'b1;
        imem.imem_addr <= pc;
      end
    end else begin
      unique case (state)
        ST_IDLE: ;
        ST_REQ: begin
          if (imem.imem_gnt) begin
            imem.imem_req <= 1'b0;
            state         <= flush ? ST_DRAIN : ST_WAIT;
          end else if (flush) begin
            imem.imem_req <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (flush) begin
            state <= imem.imem_rvalid ? ST_IDLE : ST_DRAIN;
          end else if (imem.imem_rvalid) begin
            state       <= ST_DONE;
            instr       <= imem.imem_rdata;
            instr_pc    <= imem.imem_addr;
            instr_valid <= 1'b1;
            fetch_err   <= 1'b0;
          end else if (tmo_expired) begin
            state       <= ST_DONE;
            instr       <= NOP_INSTR;
            instr_pc    <= imem.imem_addr;
            instr_valid <= 1'b1;
            fetch_err   <= 1'b1;
          end
        end
        ST_DONE: begin
          if (flush || instr_ack) begin
            state       <= ST_IDLE;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
`ifdef INSTR_ALIGN_CHECK_EN
            instr_misalign <= 1'b0;
`endif
          end
        end
        ST_DRAIN: begin
          if (imem.imem_rvalid || tmo_expired) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a flag-based reference model.
module tb_instr_fetch_ctrl;

  localparam int unsigned TIMEOUT = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef INSTR_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        fetch_req;
  logic        flush;
  logic        instr_ack;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        fetch_err;
  logic        stall;
  logic        instr_misalign;

  int checks = 0;
  int failures = 0;

  instr_fetch_ctrl_if #(.XLEN(32)) bus ();

  instr_fetch_ctrl #(.XLEN(32), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .fetch_req      (fetch_req),
    .flush          (flush),
    .instr_ack      (instr_ack),
    .imem           (bus),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .fetch_err      (fetch_err),
`ifdef INSTR_ALIGN_CHECK_EN
    .instr_misalign (instr_misalign),
`endif
    .stall          (stall)
  );

`ifndef INSTR_ALIGN_CHECK_EN
  assign instr_misalign = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: request pending, response awaited (kept or discarded), word held.
  logic        m_req, m_await, m_discard, m_valid, m_err, m_mis;
  logic [31:0] m_addr, m_instr, m_ipc;
  int          m_waited;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req <= 1'b0; m_await <= 1'b0; m_discard <= 1'b0;
      m_valid <= 1'b0; m_err <= 1'b0; m_mis <= 1'b0;
      m_addr <= '0; m_instr <= NOP; m_ipc <= '0; m_waited <= 0;
    end else if (m_req) begin
      if (bus.imem_gnt) begin
        m_req <= 1'b0; m_await <= 1'b1; m_discard <= flush; m_waited <= 0;
      end else if (flush) begin
        m_req <= 1'b0;
      end
    end else if (m_await) begin
      if (m_discard) begin
        if (bus.imem_rvalid || m_waited == TIMEOUT - 1) m_await <= 1'b0;
        else m_waited <= m_waited + 1;
      end else if (flush) begin
        if (bus.imem_rvalid) m_await <= 1'b0;
        else begin m_discard <= 1'b1; m_waited <= 0; end
      end else if (bus.imem_rvalid) begin
        m_await <= 1'b0; m_valid <= 1'b1; m_instr <= bus.imem_rdata; m_ipc <= m_addr; m_err <= 1'b0;
      end else if (m_waited == TIMEOUT - 1) begin
        m_await <= 1'b0; m_valid <= 1'b1; m_instr <= NOP; m_err <= 1'b1;
      end else begin
        m_waited <= m_waited + 1;
      end
    end else if (m_valid && (flush || !instr_ack)) begin
      if (flush) begin m_valid <= 1'b0; m_err <= 1'b0; m_mis <= 1'b0; end
    end else if (fetch_req && !flush) begin
      m_valid <= 1'b0; m_err <= 1'b0; m_mis <= 1'b0;
      if (ALIGN && pc[1:0] != 2'b00) begin
        m_valid <= 1'b1; m_mis <= 1'b1; m_instr <= NOP; m_ipc <= pc;
      end else begin
        m_req <= 1'b1; m_addr <= pc;
      end
    end else begin
      m_valid <= 1'b0; m_err <= 1'b0; m_mis <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("imem_req", 32'(bus.imem_req), 32'(m_req));
      chk("stall", 32'(stall), 32'(m_req || m_await));
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("fetch_err", 32'(fetch_err), 32'(m_err));
      chk("instr_misalign", 32'(instr_misalign), 32'(m_mis));
      if (m_req) chk("imem_addr", bus.imem_addr, m_addr);
      if (m_valid) chk("instr", instr, m_instr);
      if (m_valid && !m_err) chk("instr_pc", instr_pc, m_ipc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Start a fetch that is granted immediately and answered on the next cycle.
  task automatic quick_fetch(input logic [31:0] addr, input logic [31:0] data);
    pc = addr; fetch_req = 1'b1; tick();
    fetch_req = 1'b0; bus.imem_gnt = 1'b1; tick();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = data; tick();
    bus.imem_rvalid = 1'b0;
  endtask

  task automatic ack_it();
    instr_ack = 1'b1; tick(); instr_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pc = '0; fetch_req = 1'b0; flush = 1'b0; instr_ack = 1'b0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    repeat (2) tick();
    chk("rst imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst imem_addr", bus.imem_addr, 32'd0);
    chk("rst instr", instr, 32'h0000_0013);
    chk("rst instr_pc", instr_pc, 32'd0);
    chk("rst instr_valid", 32'(instr_valid), 32'd0);
    chk("rst fetch_err", 32'(fetch_err), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: minimum latency fetch
    pc = 32'h100; fetch_req = 1'b1; tick();
    chk("t1 c1 imem_req", 32'(bus.imem_req), 32'd1);
    chk("t1 c1 imem_addr", bus.imem_addr, 32'h100);
    chk("t1 c1 stall", 32'(stall), 32'd1);
    fetch_req = 1'b0; bus.imem_gnt = 1'b1; tick();
    chk("t1 c2 imem_req", 32'(bus.imem_req), 32'd0);
    chk("t1 c2 stall", 32'(stall), 32'd1);
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0050_0093; tick();
    bus.imem_rvalid = 1'b0;
    chk("t1 c3 instr_valid", 32'(instr_valid), 32'd1);
    chk("t1 c3 instr", instr, 32'h0050_0093);
    chk("t1 c3 instr_pc", instr_pc, 32'h100);
    chk("t1 c3 stall", 32'(stall), 32'd0);
    tick();
    chk("t1 held", 32'(instr_valid), 32'd1);
    ack_it();
    chk("t1 acked", 32'(instr_valid), 32'd0);

    // 2: grant delayed three cycles; address must not follow pc
    pc = 32'h104; fetch_req = 1'b1; tick();
    fetch_req = 1'b0; pc = 32'h999;
    for (int i = 0; i < 4; i++) begin
      chk("t2 imem_req", 32'(bus.imem_req), 32'd1);
      chk("t2 imem_addr", bus.imem_addr, 32'h104);
      bus.imem_gnt = (i == 3);
      tick();
    end
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00A0_0113; tick();
    bus.imem_rvalid = 1'b0;
    chk("t2 instr", instr, 32'h00A0_0113);
    chk("t2 instr_pc", instr_pc, 32'h104);
    ack_it();

    // 3: flush in WAIT, late response discarded, then a clean fetch
    pc = 32'h180; fetch_req = 1'b1; tick();
    fetch_req = 1'b0; bus.imem_gnt = 1'b1; tick();
    bus.imem_gnt = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    chk("t3 drain stall", 32'(stall), 32'd1);
    tick();
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; tick();
    bus.imem_rvalid = 1'b0;
    chk("t3 discarded valid", 32'(instr_valid), 32'd0);
    chk("t3 idle stall", 32'(stall), 32'd0);
    quick_fetch(32'h200, 32'h0010_8093);
    chk("t3 next instr", instr, 32'h0010_8093);
    chk("t3 next instr_pc", instr_pc, 32'h200);
    ack_it();

    // 4: response timeout
    pc = 32'h300; fetch_req = 1'b1; tick();
    fetch_req = 1'b0; bus.imem_gnt = 1'b1; tick();
    bus.imem_gnt = 1'b0;
    repeat (TIMEOUT - 1) tick();
    chk("t4 not yet", 32'(instr_valid), 32'd0);
    tick();
    chk("t4 valid", 32'(instr_valid), 32'd1);
    chk("t4 fetch_err", 32'(fetch_err), 32'd1);
    chk("t4 instr", instr, 32'h0000_0013);
    ack_it();
    chk("t4 err cleared", 32'(fetch_err), 32'd0);

    // 5: back-to-back fetch from DONE; extra fetch_req while busy is ignored
    quick_fetch(32'h400, 32'h1111_1111);
    instr_ack = 1'b1; fetch_req = 1'b1; pc = 32'h108; tick();
    instr_ack = 1'b0; pc = 32'h500;
    chk("t5 imem_req", 32'(bus.imem_req), 32'd1);
    chk("t5 imem_addr", bus.imem_addr, 32'h108);
    chk("t5 valid cleared", 32'(instr_valid), 32'd0);
    bus.imem_gnt = 1'b1; tick();
    bus.imem_gnt = 1'b0; fetch_req = 1'b0;
    chk("t5 single outstanding", 32'(bus.imem_req), 32'd0);
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h2222_2222; tick();
    bus.imem_rvalid = 1'b0;
    chk("t5 instr_pc", instr_pc, 32'h108);
    ack_it();

    // Flush in REQ without grant drops the request
    pc = 32'h600; fetch_req = 1'b1; tick();
    fetch_req = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    chk("flush req drop", 32'(bus.imem_req), 32'd0);
    chk("flush req stall", 32'(stall), 32'd0);

    // Flush with grant in REQ, then DRAIN times out silently
    pc = 32'h604; fetch_req = 1'b1; tick();
    fetch_req = 1'b0; flush = 1'b1; bus.imem_gnt = 1'b1; tick();
    flush = 1'b0; bus.imem_gnt = 1'b0;
    repeat (TIMEOUT - 1) tick();
    chk("drain still", 32'(stall), 32'd1);
    tick();
    chk("drain timeout stall", 32'(stall), 32'd0);
    chk("drain timeout err", 32'(fetch_err), 32'd0);

    // Stray rvalid in IDLE is ignored
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h3333_3333; tick();
    bus.imem_rvalid = 1'b0;
    chk("stray rvalid", 32'(instr_valid), 32'd0);

    // Flush while holding an instruction
    quick_fetch(32'h700, 32'h4444_4444);
    flush = 1'b1; fetch_req = 1'b1; instr_ack = 1'b1; tick();
    flush = 1'b0; fetch_req = 1'b0; instr_ack = 1'b0;
    chk("flush done valid", 32'(instr_valid), 32'd0);
    chk("flush done req", 32'(bus.imem_req), 32'd0);

    // Reset in WAIT; the late response must be ignored
    pc = 32'h800; fetch_req = 1'b1; tick();
    fetch_req = 1'b0; bus.imem_gnt = 1'b1; tick();
    bus.imem_gnt = 1'b0; rst_n = 1'b0; #1;
    chk("midrst stall", 32'(stall), 32'd0);
    tick();
    rst_n = 1'b1; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h5555_5555; tick();
    bus.imem_rvalid = 1'b0;
    chk("midrst valid", 32'(instr_valid), 32'd0);

`ifdef INSTR_ALIGN_CHECK_EN
    // 6: misaligned pc answered locally
    pc = 32'h102; fetch_req = 1'b1; tick();
    fetch_req = 1'b0;
    chk("t6 imem_req", 32'(bus.imem_req), 32'd0);
    chk("t6 misalign", 32'(instr_misalign), 32'd1);
    chk("t6 valid", 32'(instr_valid), 32'd1);
    chk("t6 instr", instr, 32'h0000_0013);
    chk("t6 instr_pc", instr_pc, 32'h102);
    ack_it();
    chk("t6 misalign clr", 32'(instr_misalign), 32'd0);
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
